// File: rtl/icache_direct.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// One request at a time: a hit answers on the accepting edge, and a miss refills the whole
// line word by word before it answers. An abort squashes the answer but never a refill.
module icache_direct #(
    parameter int unsigned INDEX_BITS  = 4,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        abort,
    output logic [31:0] ins_out,
    output logic        ins_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned WORDS    = 1 << OFFSET_BITS;
    localparam int unsigned TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
    localparam int unsigned TAG_BITS = 32 - TAG_LSB;

    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    // RefillDone is the extra edge between the last memory word and the answer.
    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StRefill     = 3'd1;
    localparam logic [2:0] StRefillDone = 3'd2;
    localparam logic [2:0] StResp       = 3'd3;
    localparam logic [2:0] StHold1      = 3'd4;
    localparam logic [2:0] StHold2      = 3'd5;

    // Line storage
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES*WORDS];

    // Control state
    logic [2:0]             state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]            cap_q, cap_d;
    logic                   squash_q, squash_d;
    logic [31:0]            ins_out_q, ins_out_d;
    logic                   ins_ready_q, ins_ready_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic                   data_we;
    logic                   line_we;

    // Address fields of the incoming fetch and of the latched (refilling) request
    logic [OFFSET_BITS-1:0] fetch_off;
    logic [INDEX_BITS-1:0]  fetch_idx;
    logic [TAG_BITS-1:0]    fetch_tag;
    logic [OFFSET_BITS-1:0] req_off;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]    req_tag;
    logic                   fetch_hit;
    logic [31:0]            fetch_word;
    logic                   unused_pc_bits;

    assign fetch_off = fetch_pc[OFFSET_BITS+1:2];
    assign fetch_idx = fetch_pc[TAG_LSB-1:OFFSET_BITS+2];
    assign fetch_tag = fetch_pc[31:TAG_LSB];
    assign req_off   = pc_q[OFFSET_BITS+1:2];
    assign req_idx   = pc_q[TAG_LSB-1:OFFSET_BITS+2];
    assign req_tag   = pc_q[31:TAG_LSB];

    assign fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign fetch_word = data_q[{fetch_idx, fetch_off}];

    // Byte-select bits are irrelevant for word fetches.
    assign unused_pc_bits = ^{fetch_pc[1:0], pc_q[1:0]};

    // Next-state logic; rdy_in low leaves every register at its current value.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        squash_d    = squash_q;
        ins_out_d   = ins_out_q;
        ins_ready_d = ins_ready_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        data_we     = 1'b0;
        line_we     = 1'b0;

        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    squash_d = 1'b0;
                    if (fetch_valid && !abort) begin
                        pc_d = fetch_pc;
                        if (fetch_hit) begin
                            state_d     = StResp;
                            ins_out_d   = fetch_word;
                            ins_ready_d = 1'b1;
                        end else begin
                            state_d    = StRefill;
                            mem_req_d  = 1'b1;
                            mem_addr_d = {fetch_pc[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
                            cnt_d      = '0;
                        end
                    end
                end
                StRefill: begin
                    // The refill always runs to completion; abort only kills the answer.
                    if (abort) begin
                        squash_d = 1'b1;
                    end
                    if (mem_ready) begin
                        data_we    = 1'b1;
                        mem_addr_d = mem_addr_q + 32'd4;
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == req_off) begin
                            cap_d = mem_rdata;
                        end
                        if (cnt_q == LAST_WORD) begin
                            mem_req_d = 1'b0;
                            line_we   = 1'b1;
                            state_d   = StRefillDone;
                        end
                    end
                end
                StRefillDone: begin
                    if (squash_q || abort) begin
                        state_d  = StIdle;
                        squash_d = 1'b0;
                    end else begin
                        state_d     = StResp;
                        ins_out_d   = cap_q;
                        ins_ready_d = 1'b1;
                    end
                end
                StResp: begin
                    ins_ready_d = 1'b0;
                    state_d     = abort ? StIdle : StHold1;
                end
                StHold1: begin
                    state_d = abort ? StIdle : StHold2;
                end
                StHold2: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (abort) begin
                ins_ready_d = 1'b0;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            squash_q    <= 1'b0;
            ins_out_q   <= '0;
            ins_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            squash_q    <= squash_d;
            ins_out_q   <= ins_out_d;
            ins_ready_q <= ins_ready_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Valid bits: cleared only by reset, set when a line finishes refilling.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; the valid bits guard them.
    always_ff @(posedge clk_in) begin
        if (data_we) begin
            data_q[{req_idx, cnt_q}] <= mem_rdata;
        end
        if (line_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    assign ins_out   = ins_out_q;
    assign ins_ready = ins_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: a table of directed fetches plus hand-written
// sequences for refill stepping, hold-state turnaround, abort, stall and mid-refill reset.
module tb_icache_direct;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        abort;
    logic [31:0] ins_out;
    logic        ins_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    icache_direct #(
        .INDEX_BITS (4),
        .OFFSET_BITS(2)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .fetch_valid(fetch_valid),
        .fetch_pc   (fetch_pc),
        .abort      (abort),
        .ins_out    (ins_out),
        .ins_ready  (ins_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory model: line 0 of memory holds 0x11..0x44, every other word holds 0xA0000000|addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {30'd0, a[3:2]} + 32'd1;
        if (a[31:4] == 28'd0) return 32'h11 * k;
        return 32'hA000_0000 | a;
    endfunction

    // Memory answers one cycle after each request and every cycle the request is held.
    assign mem_ready = mem_req;
    assign mem_rdata = mem_word(mem_addr);

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one fetch, wait (bounded) for the pulse, then walk back to IDLE.
    task automatic do_fetch(input logic [31:0] pc, output logic [31:0] word, output int lat);
        fetch_pc    = pc;
        fetch_valid = 1'b1;
        lat         = 0;
        word        = 32'hDEAD_BEEF;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ins_ready) begin
                lat  = i;
                word = ins_out;
                break;
            end
        end
        fetch_valid = 1'b0;
        if (lat != 0) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("no_second_pulse", {31'd0, ins_ready}, 32'd0);
            end
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] w;
        int          l;
        logic [31:0] exp_addr[4];

        // pc, expected word, ticks from request to ins_ready (1 = hit, 6 = 4-word refill)
        vecs[0]  = '{32'h0000_000C, 32'h0000_0044, 1};
        vecs[1]  = '{32'h0000_0006, 32'h0000_0022, 1};
        vecs[2]  = '{32'h0000_0100, 32'hA000_0100, 6};
        vecs[3]  = '{32'h0000_0108, 32'hA000_0108, 1};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0011, 6};
        vecs[5]  = '{32'h0000_000B, 32'h0000_0033, 1};
        vecs[6]  = '{32'h0000_0014, 32'hA000_0014, 6};
        vecs[7]  = '{32'h0000_001C, 32'hA000_001C, 1};
        vecs[8]  = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 6};
        vecs[9]  = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 1};
        vecs[10] = '{32'h0000_0010, 32'hA000_0010, 1};
        vecs[11] = '{32'h0000_0004, 32'h0000_0022, 1};

        rst_in      = 1'b0;
        rdy_in      = 1'b1;
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        abort       = 1'b0;
        tick();
        tick();
        check("rst_ins_ready", {31'd0, ins_ready}, 32'd0);
        check("rst_ins_out", ins_out, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_in = 1'b1;
        tick();

        // Cold miss at 0x0: address steps 0x0..0xC, answer one edge after the last word.
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        fetch_pc    = 32'h0;
        fetch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cold_mem_req", {31'd0, mem_req}, 32'd1);
            check("cold_mem_addr", mem_addr, exp_addr[i]);
            check("cold_no_pulse", {31'd0, ins_ready}, 32'd0);
        end
        tick();
        check("cold_req_drop", {31'd0, mem_req}, 32'd0);
        check("cold_no_pulse_yet", {31'd0, ins_ready}, 32'd0);
        tick();
        check("cold_ready", {31'd0, ins_ready}, 32'd1);
        check("cold_word", ins_out, 32'h11);
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Hit at 0x8 with fetch_valid held: no pulse in RESP/HOLD1/HOLD2, next one after IDLE.
        fetch_pc    = 32'h8;
        fetch_valid = 1'b1;
        tick();
        check("hit_ready", {31'd0, ins_ready}, 32'd1);
        check("hit_word", ins_out, 32'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_no_pulse", {31'd0, ins_ready}, 32'd0);
            check("hold_no_req", {31'd0, mem_req}, 32'd0);
        end
        tick();
        check("reaccept_ready", {31'd0, ins_ready}, 32'd1);
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_fetch(vecs[i].pc, w, l);
            check($sformatf("vec%0d_word", i), w, vecs[i].word);
            check($sformatf("vec%0d_latency", i), l, vecs[i].lat);
        end

        // Abort during IDLE: request not accepted.
        fetch_pc    = 32'h300;
        fetch_valid = 1'b1;
        abort       = 1'b1;
        tick();
        fetch_valid = 1'b0;
        abort       = 1'b0;
        check("idle_abort_no_req", {31'd0, mem_req}, 32'd0);
        check("idle_abort_no_pulse", {31'd0, ins_ready}, 32'd0);
        tick();

        // Abort in RESP: back to IDLE at once, so the next fetch is accepted immediately.
        fetch_pc    = 32'h8;
        fetch_valid = 1'b1;
        tick();
        check("resp_abort_pulse", {31'd0, ins_ready}, 32'd1);
        fetch_valid = 1'b0;
        abort       = 1'b1;
        tick();
        abort = 1'b0;
        check("resp_abort_clear", {31'd0, ins_ready}, 32'd0);
        fetch_pc    = 32'h4;
        fetch_valid = 1'b1;
        tick();
        check("resp_abort_idle", {31'd0, ins_ready}, 32'd1);
        check("resp_abort_word", ins_out, 32'h22);
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Abort after the 2nd word of a refill: line still completes, no pulse.
        fetch_pc    = 32'h228;
        fetch_valid = 1'b1;
        tick();
        tick();
        tick();
        fetch_valid = 1'b0;
        abort       = 1'b1;
        tick();
        abort = 1'b0;
        check("squash_req_held", {31'd0, mem_req}, 32'd1);
        check("squash_addr", mem_addr, 32'h22C);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("squash_no_pulse", {31'd0, ins_ready}, 32'd0);
        end
        check("squash_req_done", {31'd0, mem_req}, 32'd0);
        do_fetch(32'h228, w, l);
        check("squash_refetch_word", w, 32'hA000_0228);
        check("squash_refetch_hit", l, 1);

        // rdy_in low for 3 cycles mid-refill: ready pulses ignored, then the refill resumes.
        fetch_pc    = 32'h34C;
        fetch_valid = 1'b1;
        tick();
        tick();
        check("stall_addr_before", mem_addr, 32'h344);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr_frozen", mem_addr, 32'h344);
            check("stall_req_held", {31'd0, mem_req}, 32'd1);
        end
        rdy_in = 1'b1;
        tick();
        check("resume_addr1", mem_addr, 32'h348);
        tick();
        check("resume_addr2", mem_addr, 32'h34C);
        tick();
        check("resume_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        check("resume_ready", {31'd0, ins_ready}, 32'd1);
        check("resume_word", ins_out, 32'hA000_034C);
        fetch_valid = 1'b0;
        rdy_in      = 1'b0;
        tick();
        check("stall_pulse_held", {31'd0, ins_ready}, 32'd1);
        rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        do_fetch(32'h340, w, l);
        check("stall_word0", w, 32'hA000_0340);
        check("stall_word0_hit", l, 1);
        do_fetch(32'h344, w, l);
        check("stall_word1", w, 32'hA000_0344);

        // Reset mid-refill: outputs drop without a clock edge and the cache is emptied.
        fetch_pc    = 32'h450;
        fetch_valid = 1'b1;
        tick();
        tick();
        check("prerst_req", {31'd0, mem_req}, 32'd1);
        rst_in = 1'b0;
        #1;
        check("async_rst_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_ready", {31'd0, ins_ready}, 32'd0);
        check("async_rst_addr", mem_addr, 32'd0);
        check("async_rst_out", ins_out, 32'd0);
        fetch_valid = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        do_fetch(32'h8, w, l);
        check("postrst_word", w, 32'h33);
        check("postrst_miss", l, 6);
        do_fetch(32'hFFFF_FFF0, w, l);
        check("postrst_miss2", l, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
Direct-mapped instruction cache sitting between the instruction fetcher and the memory controller. It accepts one fetch address at a time and returns the 32-bit instruction word with a one-cycle ins_ready pulse. On a miss it refills a whole line through a word-wide memory request/ready handshake. An abort input squashes the pending response on a JALR or mispredict redirect.

Parameters:
INDEX_BITS, 4, line index width (2^INDEX_BITS lines)
OFFSET_BITS, 2, word-offset width (2^OFFSET_BITS words per line)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
rdy_in  input  1  global ready; low freezes the block
fetch_valid  input  1  fetch request level (from fetcher fetch_able)
fetch_pc  input  32  fetch address; bits [1:0] ignored
abort  input  1  redirect; squash the outstanding request
ins_out  output  32  instruction word
ins_ready  output  1  one-cycle pulse; ins_out is valid while high
mem_req  output  1  word read request to memory controller
mem_addr  output  32  word-aligned read address
mem_ready  input  1  one-cycle pulse; mem_rdata is valid
mem_rdata  input  32  returned word

Behaviour:
- Single clock. Reset is asynchronous and active-low on rst_in. rdy_in low holds all state and outputs, and mem_ready is ignored in that cycle.
- Address split: offset = pc[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, and 2^OFFSET_BITS data words.
- Reset values: all valid bits 0, state IDLE, ins_ready 0, ins_out 0, mem_req 0, mem_addr 0.
- States:
  - IDLE: on an edge with fetch_valid=1 and abort=0, latch pc.
    - Hit: next state RESP; ins_out <= stored word and ins_ready <= 1 on the same edge. Latency is 1 cycle.
    - Miss: next state REFILL; mem_req <= 1; mem_addr <= line base (pc with offset and byte bits zeroed); word counter = 0.
  - REFILL: mem_req and mem_addr are held stable until mem_ready.
    - On each mem_ready: write mem_rdata into word[counter], capture it if counter == requested offset, and increment mem_addr by 4.
    - After the last word: mem_req <= 0; valid and tag are written on the same edge.
    - Then go to RESP with ins_ready <= 1 and ins_out <= captured word, unless the request was squashed, in which case go to IDLE with no pulse.
  - RESP: ins_ready <= 0. Go to HOLD1, then HOLD2, then IDLE. fetch_valid is ignored in RESP and in both HOLD states, which covers the fetcher's turnaround while it still drives the old pc.
- Miss latency: refill handshakes plus 1 edge. With mem_ready arriving 1 cycle after each request, a 4-word line returns ins_ready 5 edges after acceptance.
- abort:
  - Highest priority. ins_ready <= 0 on the abort edge.
  - In IDLE the request is not accepted.
  - In RESP, HOLD1 or HOLD2 the state goes to IDLE.
  - In REFILL the refill continues to line completion so memory is never left mid-handshake. The line is installed, a squash flag is set, and no ins_ready is produced.
  - The squash flag clears on entry to IDLE.
- No back-to-back acceptance: at most one request is in flight. ins_ready is never high for two consecutive cycles.
- Index aliasing: a refill overwrites the indexed line regardless of its previous valid/tag.
- Reset asserted mid-refill: all lines are invalidated immediately and mem_req drops asynchronously. The memory controller also resets.
- Instruction memory is read-only; there is no write or invalidate path apart from reset.

Test Plan:
- Cold miss: reset, then fetch_pc=0x00000000 with memory returning 0x11,0x22,0x33,0x44 (1-cycle ready) -> mem_addr sequence 0x0,0x4,0x8,0xC; ins_out=0x11 with ins_ready one edge after the 4th mem_ready; mem_req 0 afterwards.
- Hit: then fetch_pc=0x00000008 -> ins_ready one edge after acceptance with ins_out=0x33; mem_req stays 0; no second pulse during HOLD1/HOLD2 even with fetch_valid held high.
- Conflict: fetch_pc=0x00000100 (index 0, new tag) -> refill of 0x100..0x10C; a later fetch of 0x0 misses and refills again.
- Abort in REFILL: assert abort after the 2nd mem_ready -> the remaining two words are still fetched, no ins_ready, state IDLE; an immediate refetch of the same pc hits in 1 cycle.
- rdy_in low for 3 cycles mid-refill while mem_ready pulses -> that pulse is ignored, mem_addr and counter are unchanged, and the refill resumes after rdy_in returns high.
- Reset mid-refill: rst_in low while mem_req=1 -> mem_req, ins_ready and all valid bits go to 0 immediately; the next fetch of a previously cached pc misses.
